// File: rtl/pipelined_adder_sub_pkg.sv
// Shared configuration for the pipelined adder/subtractor: default geometry,
// stage-count derivation and the width/chunk consistency check.
package pipelined_adder_sub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A usable geometry needs a whole number of chunks and at least one stage.
    function automatic bit geometry_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell; the building block of every chunk adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder_sub_add_chunk.sv
// Combinational CHUNK-bit ripple adder; one instance resolves one pipeline stage.
module add_chunk
    import pipelined_adder_sub_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o
);

    logic [CHUNK:0] carry;

    assign carry[0] = ci_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (a_i[i]),
            .b  (b_i[i]),
            .ci (carry[i]),
            .s  (s_o[i]),
            .co (carry[i+1])
        );
    end

    assign co_o = carry[CHUNK];

endmodule

// File: rtl/pipelined_adder_sub.sv
// WIDTH-bit add/subtract with the carry chain cut into CHUNK-bit register stages,
// valid/ready on both sides and a single global advance (stall) signal.
module pipelined_adder_sub
    import pipelined_adder_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    if (!geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
        $error("pipelined_adder_sub: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Per-stage inputs: element 0 is the prepared port data, element k>0 is
    // the register bank written by stage k-1.
    logic [WIDTH-1:0] a_st [STAGES];
    logic [WIDTH-1:0] b_st [STAGES];
    logic [WIDTH-1:0] s_st [STAGES];
    logic             c_st [STAGES];
    logic             v_st [STAGES];

    logic [WIDTH-1:0] s_nx [STAGES];
    logic             c_nx [STAGES];

    logic             adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_d;

    // Bubbles are never collapsed: the whole pipe moves or the whole pipe holds.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    assign a_st[0] = a;
    assign b_st[0] = sub ? ~b : b;
    assign s_st[0] = '0;
    assign c_st[0] = sub ? ~cin : cin;
    assign v_st[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] chunk_s;
        logic [WIDTH-1:0] s_d;

        add_chunk #(.CHUNK(CHUNK)) u_add (
            .a_i  (a_st[k][k*CHUNK +: CHUNK]),
            .b_i  (b_st[k][k*CHUNK +: CHUNK]),
            .ci_i (c_st[k]),
            .s_o  (chunk_s),
            .co_o (c_nx[k])
        );

        // Lower chunks already resolved ride along; this stage fills in chunk k.
        always_comb begin
            s_d                    = s_st[k];
            s_d[k*CHUNK +: CHUNK]  = chunk_s;
        end

        assign s_nx[k] = s_d;

        if (k < LAST) begin : g_reg
            logic             v_q;
            logic             c_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;

            // NOTE: datapath registers are reset alongside the valid bits so no
            // X from power-up can ever reach sum/cout/ovf, even on a bubble.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv) begin
                    // NOTE: non-blocking assignments so every stage samples the
                    // pre-edge value of its predecessor, giving a true shift.
                    v_q <= v_st[k];
                    c_q <= c_nx[k];
                    a_q <= a_st[k];
                    b_q <= b_st[k];
                    s_q <= s_d;
                end
            end

            assign a_st[k+1] = a_q;
            assign b_st[k+1] = b_q;
            assign s_st[k+1] = s_q;
            assign c_st[k+1] = c_q;
            assign v_st[k+1] = v_q;
        end
    end

    // Operand sign bits are still present in the last stage's operand bank.
    assign ovf_d = (a_st[LAST][WIDTH-1] == b_st[LAST][WIDTH-1]) &&
                   (s_nx[LAST][WIDTH-1] != a_st[LAST][WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v_st[LAST];
            sum_q       <= s_nx[LAST];
            cout_q      <= c_nx[LAST];
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Directed bench for pipelined_adder_sub (WIDTH=32, CHUNK=8, four stages).
module tb_pipelined_adder_sub;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks;
    int errors;

    pipelined_adder_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one transaction for a single cycle; caller guarantees in_ready=1.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tcin, input logic tsub);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        sub      = tsub;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Edges counted since the accept edge until out_valid rises; -1 on timeout.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (out_valid !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 32'hFFFF_FFFF;
        b         = 32'h0000_0001;
        cin       = 1'b1;
        sub       = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (sum !== 32'h0) begin
            errors++;
            $display("FAIL reset_sum got %h exp 00000000", sum);
        end
        checks++;
        if (cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_cout got %b exp 0", cout);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b exp 0", ovf);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_full_carry;
        int cyc;
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL carry_latency got %0d exp 4", cyc);
        end
        checks++;
        if (sum !== 32'h0000_0000) begin
            errors++;
            $display("FAIL carry_sum got %h exp 00000000", sum);
        end
        checks++;
        if (cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_cout got %b exp 1", cout);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_ovf got %b exp 0", ovf);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL carry_single_result got out_valid %b exp 0", out_valid);
        end
    endtask

    task automatic test_overflow;
        int cyc;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL ovf_latency got %0d exp 4", cyc);
        end
        checks++;
        if ({sum, cout, ovf} !== {32'h8000_0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_result got sum %h cout %b ovf %b exp sum 80000000 cout 0 ovf 1",
                     sum, cout, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_subtract;
        int cyc;
        send(32'd5, 32'd7, 1'b0, 1'b1);
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow got lat %0d sum %h cout %b ovf %b exp lat 4 sum fffffffe cout 0 ovf 0",
                     cyc, sum, cout, ovf);
        end
        @(negedge clk);
        send(32'd7, 32'd5, 1'b1, 1'b1);
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {sum, cout, ovf} !== {32'h0000_0001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow_in got lat %0d sum %h cout %b ovf %b exp lat 4 sum 00000001 cout 1 ovf 0",
                     cyc, sum, cout, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] got[$];
        logic [WIDTH-1:0] cap;
        int               n_in;
        int               stall;
        int               extra;
        bit               seen;
        bit               stalled;
        bit               fin;
        bit               fout;
        n_in      = 0;
        stall     = 0;
        extra     = 0;
        seen      = 1'b0;
        fin       = 1'b0;
        fout      = 1'b0;
        cap       = '0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
            @(negedge clk);
            if (fin) n_in++;
            if (fout) got.push_back(cap);
            if (out_valid === 1'b1 && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            stalled   = (stall > 0);
            if (stalled) stall--;
            out_ready = !stalled;
            in_valid  = (n_in < 6);
            a         = WIDTH'(n_in + 1);
            b         = WIDTH'(n_in + 1);
            cin       = 1'b0;
            sub       = 1'b0;
            #1;
            if (stalled) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got %b exp 0", in_ready);
                end
                checks++;
                if (out_valid !== 1'b1 || sum !== 32'd2) begin
                    errors++;
                    $display("FAIL stall_hold got valid %b sum %0d exp valid 1 sum 2", out_valid, sum);
                end
            end
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            cap  = sum;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got.size() !== 6) begin
            errors++;
            $display("FAIL stream_count got %0d exp 6", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== WIDTH'(2 * (i + 1))) begin
                errors++;
                $display("FAIL stream_order idx %0d got %0d exp %0d", i, got[i], 2 * (i + 1));
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL stream_duplicate got %0d extra results exp 0", extra);
        end
    endtask

    task automatic test_reset_mid_flight;
        int cyc;
        int extra;
        // Two accepts, then reset while both are still inside the pipe.
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'd3;
        b        = 32'd4;
        cin      = 1'b0;
        sub      = 1'b0;
        @(negedge clk);
        a = 32'd10;
        b = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0) begin
            errors++;
            $display("FAIL midflight_reset got valid %b sum %h exp valid 0 sum 00000000", out_valid, sum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL midflight_ghost got %0d results exp 0", extra);
        end

        // Held result with no clock edge: reset must clear it asynchronously.
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || sum !== 32'h2345_678A || cout !== 1'b0) begin
            errors++;
            $display("FAIL held_result got lat %0d sum %h cout %b exp lat 4 sum 2345678a cout 0",
                     cyc, sum, cout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got valid %b sum %h exp valid 0 sum 00000000", out_valid, sum);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        extra     = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL async_reset_ghost got %0d results exp 0", extra);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_carry();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_mid_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
